// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first,
// one full-subtractor cell with a registered borrow.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, next;

   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic load, step, last;
   logic d, bo;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .diff (d),
      .bout (bo)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // next state, handshake outputs and datapath strobes
   always_comb begin
      next = state;
      busy = 1'b0;
      done = 1'b0;
      load = 1'b0;
      step = 1'b0;
      last = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               next = SHIFT;
               load = 1'b1;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST) begin
               last = 1'b1;
               next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   // operand shift, borrow chain and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else if (load) begin
         a_sr   <= a;
         b_sr   <= b;
         res_sr <= '0;
         borrow <= bin;
         cnt    <= '0;
      end else if (step) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {d, res_sr[WIDTH-1:1]};
         borrow <= bo;
         cnt    <= cnt + CW'(1);
         if (last) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= bo;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor
// (WIDTH=8): timing, arithmetic, reset, start handling.

module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b, diff;
   logic       bin, busy, done, bout;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   // drives one op from an idle sample point; observes
   // samples k=0..29 after edges E0..E29. optional start
   // glitch with other operands at sample pk.
   task automatic do_op(
      input  logic [7:0] ia, ib,
      input  logic       ibin,
      input  int         pk,
      input  logic [7:0] pa, pb,
      output logic [7:0] od,
      output logic       ob,
      output int         nbusy,
      output int         dedge,
      output int         ndone
   );
      start = 1'b1; a = ia; b = ib; bin = ibin;
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ia; b = ~ib; bin = ~ibin;
      nbusy = 0; dedge = -1; ndone = 0;
      od = 'x; ob = 1'bx;
      for (int k = 0; k < 30; k++) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (dedge < 0) begin
               dedge = k; od = diff; ob = bout;
            end
         end
         if (k == pk) begin
            start = 1'b1; a = pa; b = pb; bin = 1'b0;
         end else if (k == pk + 1) begin
            start = 1'b0;
         end
         if (k < 29) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset;
      logic [7:0] od; logic ob; int nb, de, nd;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      #12;
      checks++;
      if ({busy, done, diff, bout} !== 11'd0) begin
         failures++;
         $display("FAIL reset_power busy=%b done=%b diff=%h bout=%b want 0",
                  busy, done, diff, bout);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      do_op(8'hC3, 8'h01, 1'b0, -1, 8'h0, 8'h0, od, ob, nb, de, nd);
      checks++;
      if (diff !== 8'hC2) begin
         failures++;
         $display("FAIL reset_pre diff=%h want c2", diff);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, diff, bout} !== 11'd0) begin
         failures++;
         $display("FAIL reset_async busy=%b done=%b diff=%h bout=%b want 0",
                  busy, done, diff, bout);
      end
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [7:0] od; logic ob; int nb, de, nd;
      do_op(8'h5A, 8'h23, 1'b0, -1, 8'h0, 8'h0, od, ob, nb, de, nd);
      checks++;
      if (nb != 8) begin
         failures++;
         $display("FAIL basic_busy cycles=%0d want 8", nb);
      end
      checks++;
      if (de != 8 || nd != 1) begin
         failures++;
         $display("FAIL basic_done edge=%0d pulses=%0d want 8/1", de, nd);
      end
      checks++;
      if ({ob, od} !== {1'b0, 8'h37}) begin
         failures++;
         $display("FAIL basic_result got %b/%h want 0/37", ob, od);
      end
   endtask

   task automatic test_corners;
      logic [7:0] va [3] = '{8'h10, 8'h00, 8'hFF};
      logic [7:0] vb [3] = '{8'h20, 8'h00, 8'hFF};
      logic       vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] vd [3] = '{8'hF0, 8'hFF, 8'hFF};
      logic       vo [3] = '{1'b1, 1'b1, 1'b1};
      logic [7:0] od; logic ob; int nb, de, nd;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], vc[i], -1, 8'h0, 8'h0, od, ob, nb, de, nd);
         checks++;
         if ({ob, od} !== {vo[i], vd[i]} || de != 8) begin
            failures++;
            $display("FAIL corner%0d got %b/%h edge=%0d want %b/%h edge=8",
                     i, ob, od, de, vo[i], vd[i]);
         end
      end
      do_op(8'h3C, 8'h3C, 1'b0, -1, 8'h0, 8'h0, od, ob, nb, de, nd);
      checks++;
      if ({ob, od} !== 9'd0) begin
         failures++;
         $display("FAIL equal got %b/%h want 0/00", ob, od);
      end
   endtask

   task automatic test_start_ignored;
      logic [7:0] od; logic ob; int nb, de, nd;
      do_op(8'h5A, 8'h23, 1'b0, 3, 8'h01, 8'h01, od, ob, nb, de, nd);
      checks++;
      if ({ob, od} !== {1'b0, 8'h37} || de != 8) begin
         failures++;
         $display("FAIL ignore_result got %b/%h edge=%0d want 0/37 edge=8",
                  ob, od, de);
      end
      checks++;
      if (nd != 1 || nb != 8) begin
         failures++;
         $display("FAIL ignore_pulses done=%0d busy=%0d want 1/8", nd, nb);
      end
   endtask

   task automatic test_abort;
      logic [7:0] od; logic ob; int nb, de, nd, seen;
      start = 1'b1; a = 8'h5A; b = 8'h23; bin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, diff, bout} !== 11'd0) begin
         failures++;
         $display("FAIL abort_outputs busy=%b done=%b diff=%h bout=%b want 0",
                  busy, done, diff, bout);
      end
      @(posedge clk); #1; rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) seen++;
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_quiet active=%0d want 0", seen);
      end
      do_op(8'h80, 8'h01, 1'b0, -1, 8'h0, 8'h0, od, ob, nb, de, nd);
      checks++;
      if ({ob, od} !== {1'b0, 8'h7F} || de != 8) begin
         failures++;
         $display("FAIL abort_next got %b/%h edge=%0d want 0/7f edge=8",
                  ob, od, de);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] ca, cb; logic cc;
      logic [8:0] exp;
      int de;
      ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
      start = 1'b1; a = ca; b = cb; bin = cc;
      @(posedge clk); #1;
      for (int n = 0; n < 500; n++) begin
         exp = {1'b0, ca} - {1'b0, cb} - {8'b0, cc};
         a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
         de = -1;
         for (int k = 1; k <= 12 && de < 0; k++) begin
            @(posedge clk); #1;
            if (done) de = k;
         end
         checks++;
         if (de != 8) begin
            failures++;
            $display("FAIL b2b_timing op=%0d done_edge=%0d want 8", n, de);
         end
         checks++;
         if ({bout, diff} !== exp) begin
            failures++;
            $display("FAIL b2b_result op=%0d a=%h b=%h bin=%b got %b/%h want %b/%h",
                     n, ca, cb, cc, bout, diff, exp[8], exp[7:0]);
         end
         ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
         a = ca; b = cb; bin = cc;
         @(posedge clk); #1;
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept op=%0d busy=%b want 1", n, busy);
         end
      end
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_corners;
      test_start_ignored;
      test_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
